inst_rom_arbiter: RTL and testbench

Sequencing and arbitration controller in front of the single-port instruction ROM. It shares the ROM between two requesters:
- the CPU fetch stage (IF);
- a debug/loader read port (DBG), used to dump program memory.

It inserts a configurable number of ROM wait states and registers returned words. It raises a stall request to the pipeline controller while a CPU fetch is outstanding.

---
 rtl/inst_rom_arbiter_pkg.sv | 31 +++
 rtl/inst_rom_grant.sv | 59 +++++
 rtl/inst_rom_arbiter.sv | 121 ++++++++++++
 tb/tb_inst_rom_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and types for the instruction ROM arbiter.
//   InstAddrBus / InstBus : ROM address and data widths
//   ZeroWord              : all-zero bus value
//   ChipEnable/ChipDisable: ROM chip-enable encoding
//   arb_state_t           : ArbIdle / ArbBusy
//   arb_owner_t           : OwnerIf / OwnerDbg
package inst_rom_arbiter_pkg;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;

    typedef enum logic {
        ArbIdle = 1'b0,
        ArbBusy = 1'b1
    } arb_state_t;

    typedef enum logic {
        OwnerIf  = 1'b0,
        OwnerDbg = 1'b1
    } arb_owner_t;

    // The ROM is word addressed; byte offset bits are forced to zero.
    function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_rom_grant.sv
// Grant selection between the CPU fetch port and the debug read port.
//   clk, rst_n    : clock, async active-low reset
//   grant_en      : arbiter is idle and may start an access
//   if_req, flush : CPU fetch request and pipeline flush
//   if_ack        : CPU ack currently driven (request ignored this cycle)
//   dbg_req       : debug read request
//   dbg_ack       : debug ack currently driven (request ignored this cycle)
//   grant_valid   : an access starts this cycle
//   grant_owner   : winner (OwnerIf / OwnerDbg)
//   streak        : consecutive IF grants while DBG was requesting
module inst_rom_grant
    import inst_rom_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       grant_en,
    input  logic       if_req,
    input  logic       flush,
    input  logic       if_ack,
    input  logic       dbg_req,
    input  logic       dbg_ack,
    output logic       grant_valid,
    output logic       grant_owner,
    output logic [2:0] streak
);

    localparam logic [2:0] StreakMax = 3'(MAX_STREAK);

    logic if_elig;
    logic dbg_elig;
    logic dbg_win;

    always_comb begin
        if_elig     = if_req & ~if_ack & ~flush;
        dbg_elig    = dbg_req & ~dbg_ack;
        // IF wins unless DBG has been starved for MAX_STREAK IF grants.
        dbg_win     = dbg_elig & (~if_elig | (streak == StreakMax));
        grant_valid = grant_en & (if_elig | dbg_elig);
        grant_owner = dbg_win ? OwnerDbg : OwnerIf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= 3'd0;
        end else if (!dbg_req) begin
            streak <= 3'd0;
        end else if (grant_valid) begin
            if (grant_owner == OwnerDbg) begin
                streak <= 3'd0;
            end else if (streak != 3'd7) begin
                // Saturate so the counter can never wrap past the threshold.
                streak <= streak + 3'd1;
            end
        end
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the single-port instruction ROM between the CPU fetch stage and a
// debug read port, inserts WAIT_CYCLES wait states, registers returned words
// and raises stallreq while a CPU fetch is outstanding.
//   clk, rst_n          : clock, async active-low reset
//   if_req/if_addr      : CPU fetch request and byte address
//   flush               : cancels the CPU fetch
//   if_inst/if_ack      : registered instruction and one-cycle ack
//   stallreq            : pipeline stall request (combinational)
//   dbg_req/dbg_addr    : debug read request and byte address
//   dbg_data/dbg_ack    : registered debug data and one-cycle ack
//   rom_ce/rom_addr     : ROM chip enable and word address
//   rom_inst            : ROM data, combinational from rom_addr
//
// state   | meaning
// ArbIdle | ROM disabled, address zero; grants a new access
// ArbBusy | ROM enabled on the latched word address, counting wait states
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int MAX_STREAK  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    input  logic                   flush,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_ack,
    output logic                   stallreq,
    input  logic                   dbg_req,
    input  logic [InstAddrBus-1:0] dbg_addr,
    output logic [InstBus-1:0]     dbg_data,
    output logic                   dbg_ack,
    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic [InstBus-1:0]     rom_inst
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    arb_state_t state;
    arb_owner_t owner;
    logic [3:0] cnt;
    logic       cancel;
    logic       grant_valid;
    logic       grant_owner;
    logic [2:0] streak;

    inst_rom_grant #(
        .MAX_STREAK (MAX_STREAK)
    ) u_grant (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant_en    (state == ArbIdle),
        .if_req      (if_req),
        .flush       (flush),
        .if_ack      (if_ack),
        .dbg_req     (dbg_req),
        .dbg_ack     (dbg_ack),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner),
        .streak      (streak)
    );

    assign stallreq = if_req & ~if_ack & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ArbIdle;
            owner    <= OwnerIf;
            cnt      <= 4'd0;
            cancel   <= 1'b0;
            if_inst  <= ZeroWord;
            dbg_data <= ZeroWord;
            if_ack   <= 1'b0;
            dbg_ack  <= 1'b0;
            rom_ce   <= ChipDisable;
            rom_addr <= ZeroWord;
        end else begin
            if_ack  <= 1'b0;
            dbg_ack <= 1'b0;
            case (state)
                ArbIdle: begin
                    if (grant_valid) begin
                        state    <= ArbBusy;
                        owner    <= arb_owner_t'(grant_owner);
                        cnt      <= WaitInit;
                        cancel   <= 1'b0;
                        rom_ce   <= ChipEnable;
                        rom_addr <= word_align((grant_owner == OwnerDbg) ? dbg_addr : if_addr);
                    end
                end
                ArbBusy: begin
                    // A flushed fetch still runs to completion on the ROM;
                    // cancel only suppresses its result.
                    if (owner == OwnerIf && flush) begin
                        cancel <= 1'b1;
                    end
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= ArbIdle;
                        cancel   <= 1'b0;
                        rom_ce   <= ChipDisable;
                        rom_addr <= ZeroWord;
                        if (owner == OwnerDbg) begin
                            dbg_data <= rom_inst;
                            dbg_ack  <= 1'b1;
                        end else if (!(cancel | flush)) begin
                            if_inst <= rom_inst;
                            if_ack  <= 1'b1;
                        end
                    end
                end
                default: state <= ArbIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
module tb_inst_rom_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    // instance a: WAIT_CYCLES=0, MAX_STREAK=4
    logic        if_req_a, flush_a, dbg_req_a;
    logic [31:0] if_addr_a, dbg_addr_a;
    logic [31:0] if_inst_a, dbg_data_a, rom_addr_a, rom_inst_a;
    logic        if_ack_a, dbg_ack_a, stallreq_a, rom_ce_a;

    // instance b: WAIT_CYCLES=3, MAX_STREAK=1
    logic        if_req_b, flush_b, dbg_req_b;
    logic [31:0] if_addr_b, dbg_addr_b;
    logic [31:0] if_inst_b, dbg_data_b, rom_addr_b, rom_inst_b;
    logic        if_ack_b, dbg_ack_b, stallreq_b, rom_ce_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'h0000_0008) return 32'h3401_1100;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    assign rom_inst_a = rom_word(rom_addr_a);
    assign rom_inst_b = rom_word(rom_addr_b);

    inst_rom_arbiter #(.WAIT_CYCLES(0), .MAX_STREAK(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_a), .if_addr(if_addr_a), .flush(flush_a),
        .if_inst(if_inst_a), .if_ack(if_ack_a), .stallreq(stallreq_a),
        .dbg_req(dbg_req_a), .dbg_addr(dbg_addr_a),
        .dbg_data(dbg_data_a), .dbg_ack(dbg_ack_a),
        .rom_ce(rom_ce_a), .rom_addr(rom_addr_a), .rom_inst(rom_inst_a)
    );

    inst_rom_arbiter #(.WAIT_CYCLES(3), .MAX_STREAK(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_b), .if_addr(if_addr_b), .flush(flush_b),
        .if_inst(if_inst_b), .if_ack(if_ack_b), .stallreq(stallreq_b),
        .dbg_req(dbg_req_b), .dbg_addr(dbg_addr_b),
        .dbg_data(dbg_data_b), .dbg_ack(dbg_ack_b),
        .rom_ce(rom_ce_b), .rom_addr(rom_addr_b), .rom_inst(rom_inst_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // acks of one instance must never overlap
    always @(negedge clk) begin
        chk("ack_excl_a", {31'd0, if_ack_a & dbg_ack_a}, 32'd0);
        chk("ack_excl_b", {31'd0, if_ack_b & dbg_ack_b}, 32'd0);
    end

    initial begin
        rst_n = 1'b0;
        {if_req_a, flush_a, dbg_req_a, if_req_b, flush_b, dbg_req_b} = '0;
        {if_addr_a, dbg_addr_a, if_addr_b, dbg_addr_b} = '0;
        #2;
        chk("rst_if_inst", if_inst_a, 32'd0);
        chk("rst_dbg_data", dbg_data_a, 32'd0);
        chk("rst_acks", {30'd0, if_ack_a, dbg_ack_a}, 32'd0);
        chk("rst_rom_ce", {31'd0, rom_ce_a}, 32'd0);
        chk("rst_rom_addr", rom_addr_a, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq_a}, 32'd0);
        chk("rst_streak", {29'd0, dut_a.u_grant.streak}, 32'd0);
        #10 rst_n = 1'b1;
        step();

        // single IF fetch, zero wait states
        step(); if_req_a = 1'b1; if_addr_a = 32'h8; #1;
        chk("t1_c0_stall", {31'd0, stallreq_a}, 32'd1);
        chk("t1_c0_ce", {31'd0, rom_ce_a}, 32'd0);
        step();
        chk("t1_c1_ce", {31'd0, rom_ce_a}, 32'd1);
        chk("t1_c1_addr", rom_addr_a, 32'h8);
        chk("t1_c1_stall", {31'd0, stallreq_a}, 32'd1);
        chk("t1_c1_ack", {31'd0, if_ack_a}, 32'd0);
        step();
        chk("t1_c2_ack", {31'd0, if_ack_a}, 32'd1);
        chk("t1_c2_inst", if_inst_a, 32'h3401_1100);
        chk("t1_c2_stall", {31'd0, stallreq_a}, 32'd0);
        chk("t1_c2_ce", {31'd0, rom_ce_a}, 32'd0);
        step(); if_req_a = 1'b0; #1;
        chk("t1_c3_ack", {31'd0, if_ack_a}, 32'd0);
        chk("t1_c3_inst_hold", if_inst_a, 32'h3401_1100);

        // simultaneous IF and DBG: IF first, DBG right after
        step(); if_req_a = 1'b1; if_addr_a = 32'h4; dbg_req_a = 1'b1; dbg_addr_a = 32'h10; #1;
        chk("t2_c0_ce", {31'd0, rom_ce_a}, 32'd0);
        step();
        chk("t2_c1_addr", rom_addr_a, 32'h4);
        step();
        chk("t2_c2_if_ack", {31'd0, if_ack_a}, 32'd1);
        chk("t2_c2_dbg_ack", {31'd0, dbg_ack_a}, 32'd0);
        chk("t2_c2_inst", if_inst_a, rom_word(32'h4));
        step(); if_req_a = 1'b0; #1;
        chk("t2_c3_addr", rom_addr_a, 32'h10);
        chk("t2_c3_ce", {31'd0, rom_ce_a}, 32'd1);
        chk("t2_c3_acks", {30'd0, if_ack_a, dbg_ack_a}, 32'd0);
        step();
        chk("t2_c4_dbg_ack", {31'd0, dbg_ack_a}, 32'd1);
        chk("t2_c4_if_ack", {31'd0, if_ack_a}, 32'd0);
        chk("t2_c4_data", dbg_data_a, rom_word(32'h10));
        step(); dbg_req_a = 1'b0; #1;
        chk("t2_c5_dbg_ack", {31'd0, dbg_ack_a}, 32'd0);
        step();

        // both held: the ack cycle hands the ROM to the other requester
        for (int k = 0; k <= 12; k++) begin
            step();
            if (k == 0) begin
                if_req_a = 1'b1; if_addr_a = 32'h20; dbg_req_a = 1'b1; dbg_addr_a = 32'h40;
            end
            if (k == 12) begin
                if_req_a = 1'b0; dbg_req_a = 1'b0;
            end
            #1;
            chk($sformatf("t3_if_ack_k%0d", k), {31'd0, if_ack_a},
                {31'd0, (k >= 2) && ((k - 2) % 4 == 0)});
            chk($sformatf("t3_dbg_ack_k%0d", k), {31'd0, dbg_ack_a},
                {31'd0, (k >= 4) && (k % 4 == 0)});
            chk($sformatf("t3_addr_k%0d", k), rom_addr_a,
                (k % 4 == 1) ? 32'h20 : (k % 4 == 3) ? 32'h40 : 32'h0);
            if (k == 1) chk("t3_streak_k1", {29'd0, dut_a.u_grant.streak}, 32'd1);
            if (k == 3) chk("t3_streak_k3", {29'd0, dut_a.u_grant.streak}, 32'd0);
            if (k == 10) chk("t3_inst_k10", if_inst_a, rom_word(32'h20));
            if (k == 12) chk("t3_data_k12", dbg_data_a, rom_word(32'h40));
        end
        step();

        // flushed IF grants build up streak until DBG is forced through
        for (int k = 0; k <= 13; k++) begin
            step();
            if (k == 0) begin
                if_req_a = 1'b1; if_addr_a = 32'h60; dbg_req_a = 1'b1; dbg_addr_a = 32'h50;
            end
            flush_a = (k == 1 || k == 3 || k == 5 || k == 7);
            if (k == 11) dbg_req_a = 1'b0;
            if (k == 13) if_req_a = 1'b0;
            #1;
            chk($sformatf("t4_addr_k%0d", k), rom_addr_a,
                (k == 1 || k == 3 || k == 5 || k == 7 || k == 11) ? 32'h60 :
                (k == 9) ? 32'h50 : 32'h0);
            chk($sformatf("t4_if_ack_k%0d", k), {31'd0, if_ack_a}, {31'd0, k == 12});
            chk($sformatf("t4_dbg_ack_k%0d", k), {31'd0, dbg_ack_a}, {31'd0, k == 10});
            chk($sformatf("t4_stall_k%0d", k), {31'd0, stallreq_a},
                {31'd0, !(k == 1 || k == 3 || k == 5 || k == 7 || k >= 12)});
            if (k == 8) chk("t4_streak_k8", {29'd0, dut_a.u_grant.streak}, 32'd4);
            if (k == 9) chk("t4_streak_k9", {29'd0, dut_a.u_grant.streak}, 32'd0);
            if (k == 9) chk("t4_inst_hold", if_inst_a, rom_word(32'h20));
            if (k == 10) chk("t4_dbg_data", dbg_data_a, rom_word(32'h50));
            if (k == 12) chk("t4_inst_new", if_inst_a, rom_word(32'h60));
        end
        flush_a = 1'b0;
        step();

        // three wait states, single debug read
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 0) begin dbg_req_b = 1'b1; dbg_addr_b = 32'hC; end
            if (k == 6) dbg_req_b = 1'b0;
            #1;
            chk($sformatf("t5_ce_k%0d", k), {31'd0, rom_ce_b}, {31'd0, k >= 1 && k <= 4});
            chk($sformatf("t5_addr_k%0d", k), rom_addr_b, (k >= 1 && k <= 4) ? 32'hC : 32'h0);
            chk($sformatf("t5_dbg_ack_k%0d", k), {31'd0, dbg_ack_b}, {31'd0, k == 5});
            if (k == 5) chk("t5_data", dbg_data_b, rom_word(32'hC));
        end

        // flush during a waited IF access; request is re-served afterwards
        for (int k = 0; k <= 11; k++) begin
            step();
            if (k == 0) begin if_req_b = 1'b1; if_addr_b = 32'h100; end
            flush_b = (k == 2);
            if (k == 11) if_req_b = 1'b0;
            #1;
            chk($sformatf("t6_ack_k%0d", k), {31'd0, if_ack_b}, {31'd0, k == 10});
            chk($sformatf("t6_stall_k%0d", k), {31'd0, stallreq_b},
                {31'd0, !(k == 2 || k >= 10)});
            chk($sformatf("t6_ce_k%0d", k), {31'd0, rom_ce_b},
                {31'd0, (k >= 1 && k <= 4) || (k >= 6 && k <= 9)});
            chk($sformatf("t6_inst_k%0d", k), if_inst_b, (k >= 10) ? rom_word(32'h100) : 32'h0);
        end
        flush_b = 1'b0;
        step();

        // reset in the middle of an access
        step(); if_req_b = 1'b1; if_addr_b = 32'h200; #1;
        step();
        step();
        chk("t7_busy_ce", {31'd0, rom_ce_b}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_ce", {31'd0, rom_ce_b}, 32'd0);
        chk("t7_rst_addr", rom_addr_b, 32'd0);
        chk("t7_rst_inst_b", if_inst_b, 32'd0);
        chk("t7_rst_inst_a", if_inst_a, 32'd0);
        chk("t7_rst_data_a", dbg_data_a, 32'd0);
        step();
        step();
        chk("t7_hold_ce", {31'd0, rom_ce_b}, 32'd0);
        chk("t7_hold_ack", {31'd0, if_ack_b}, 32'd0);
        rst_n = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j == 6) if_req_b = 1'b0;
            #1;
            chk($sformatf("t7_ack_j%0d", j), {31'd0, if_ack_b}, {31'd0, j == 5});
            chk($sformatf("t7_ce_j%0d", j), {31'd0, rom_ce_b}, {31'd0, j >= 1 && j <= 4});
            if (j == 5) chk("t7_inst", if_inst_b, rom_word(32'h200));
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
